// File: rtl/line_mem_responder.sv
// Line-memory responder: 512 x 256-bit lines serving a D-cache initiator.
// Ports: clk_i/rst_i (async low), addr_i/data_i/write_i/enable_i request,
// ack_o/err_o one-cycle completion, data_o registered read line.
// Optional: LINE_MEM_STATS_EN adds rd_cnt_o/wr_cnt_o in-range op counters.
`timescale 1ns/1ps
module line_mem_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         err_o
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0]  rd_cnt_o,
  output logic [15:0]  wr_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [255:0]     r_mem [DEPTH];
  logic [7:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_wr;
  logic [255:0]     r_wdata;
  logic             r_oor;
  logic             r_ack;
  logic             r_err;
  logic [255:0]     r_rdata;

  logic             w_done;
  logic             w_oor;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused;

  assign w_idx    = addr_i[IDX_W+4:5];
  assign w_oor    = |addr_i[31:IDX_W+5];
  assign w_unused = ^addr_i[4:0];
  assign w_done   = (r_state == S_BUSY) && (r_cnt == 8'd0);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (enable_i) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 8'd0) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_oor   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_done;
      r_err   <= w_done & r_oor;
      if (r_state == S_IDLE && enable_i) begin
        r_idx   <= w_idx;
        r_wr    <= write_i;
        r_wdata <= data_i;
        r_oor   <= w_oor;
        r_cnt   <= 8'(LATENCY - 1);
      end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_done && !r_wr)
        r_rdata <= r_oor ? '0 : r_mem[r_idx];
    end
  end

  // No reset: contents survive reset; reset forces IDLE so no write fires.
  always_ff @(posedge clk_i) begin
    if (w_done && r_wr && !r_oor)
      r_mem[r_idx] <= r_wdata;
  end

  assign ack_o  = r_ack;
  assign err_o  = r_err;
  assign data_o = r_rdata;

`ifdef LINE_MEM_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_done && !r_oor) begin
      if (!r_wr && r_rd_cnt != 16'hFFFF)
        r_rd_cnt <= r_rd_cnt + 16'd1;
      if (r_wr && r_wr_cnt != 16'hFFFF)
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LATENCY=10).
// Covers reads, writes, out-of-range, back-to-back, reset abort, stats.
`timescale 1ns/1ps
module tb_line_mem_responder;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] wdat;
  logic         en;
  logic         wr;
  logic         ack;
  logic [255:0] rdat;
  logic         err;
`ifdef LINE_MEM_STATS_EN
  logic [15:0]  rd_cnt;
  logic [15:0]  wr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] M1 =
    256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444_5555_6666_7777_0000;
  localparam logic [255:0] ECFA = {16{16'hECFA}};
  localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};

  logic [255:0] shadow [512];

  line_mem_responder #(.LATENCY(10)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (wdat),
    .enable_i (en),
    .write_i  (wr),
    .ack_o    (ack),
    .data_o   (rdat),
    .err_o    (err)
`ifdef LINE_MEM_STATS_EN
    ,
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [255:0] d,
                     input logic w, output int lat, output logic e,
                     output logic after);
    @(negedge clk);
    addr = a; wdat = d; wr = w; en = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 300);
    e = err;
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    after = ack;
  endtask

  initial begin
    int   lat;
    int   n;
    int   bad;
    logic e;
    logic after;

    rst = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdat = '0;
    for (int i = 0; i < 512; i++) begin
      shadow[i] = (i == 1) ? M1 : pat(i);
      dut.r_mem[i] = shadow[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 256'(ack), 256'd0);
    chk("rst_err", 256'(err), 256'd0);
    chk("rst_data", rdat, 256'd0);
    @(negedge clk);
    rst = 1'b1;

    // Read line 1
    req(32'h20, '0, 1'b0, lat, e, after);
    chk("rd1_lat", 256'(lat), 256'd10);
    chk("rd1_err", 256'(e), 256'd0);
    chk("rd1_data", rdat, M1);
    chk("rd1_pulse", 256'(after), 256'd0);

    // Write line 2, then read it back
    req(32'h40, ECFA, 1'b1, lat, e, after);
    chk("wr2_lat", 256'(lat), 256'd10);
    chk("wr2_err", 256'(e), 256'd0);
    chk("wr2_data_hold", rdat, M1);
    shadow[2] = ECFA;
    chk("wr2_mem", dut.r_mem[2], ECFA);
    req(32'h40, '0, 1'b0, lat, e, after);
    chk("rd2_data", rdat, ECFA);

    // Out-of-range read and write
    req(32'h0001_0000, '0, 1'b0, lat, e, after);
    chk("oor_rd_err", 256'(e), 256'd1);
    chk("oor_rd_data", rdat, 256'd0);
    chk("oor_rd_lat", 256'(lat), 256'd10);
    req(32'h0001_0000, JUNK, 1'b1, lat, e, after);
    chk("oor_wr_err", 256'(e), 256'd1);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (dut.r_mem[i] !== shadow[i]) bad++;
    chk("oor_wr_mem", 256'(bad), 256'd0);

    // Back-to-back reads with enable held through ack
    @(negedge clk);
    addr = 32'h0; wr = 1'b0; en = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 300);
    chk("b2b_first_lat", 256'(n), 256'd10);
    chk("b2b_first_data", rdat, shadow[0]);
    @(negedge clk);
    addr = 32'h200;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((n < 2 || !ack) && n < 300);
    chk("b2b_spacing", 256'(n), 256'd12);
    chk("b2b_second_data", rdat, shadow[16]);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);

    // Reset three cycles into a write of line 32
    @(negedge clk);
    addr = 32'h400; wdat = JUNK; wr = 1'b1; en = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    #1;
    chk("abort_ack", 256'(ack), 256'd0);
    chk("abort_data", rdat, 256'd0);
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ack) bad++;
    end
    chk("abort_no_ack", 256'(bad), 256'd0);
    chk("abort_mem", dut.r_mem[32], shadow[32]);
    @(negedge clk);
    rst = 1'b1; addr = 32'h400; wr = 1'b0; en = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 300);
    chk("post_rst_lat", 256'(n), 256'd10);
    chk("post_rst_data", rdat, shadow[32]);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);

`ifdef LINE_MEM_STATS_EN
    req(32'h20, '0, 1'b0, lat, e, after);
    req(32'h40, '0, 1'b0, lat, e, after);
    req(32'hA0, ECFA, 1'b1, lat, e, after);
    req(32'hC0, JUNK, 1'b1, lat, e, after);
    req(32'h0002_0000, '0, 1'b0, lat, e, after);
    chk("stats_rd", 256'(rd_cnt), 256'd3);
    chk("stats_wr", 256'(wr_cnt), 256'd2);
    chk("stats_wr_mem", dut.r_mem[6], JUNK);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
